// File: rtl/watch_key_ctrl_pkg.sv
// Shared types and constants for the watch controller: display modes, key
// command encodings and the wrap limits of the three time fields.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_t;

    localparam logic [3:0] KEY_MODE = 4'd0;
    localparam logic [3:0] KEY_INC  = 4'd1;
    localparam logic [3:0] KEY_DEC  = 4'd2;
    localparam logic [3:0] KEY_CLR  = 4'd3;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

    // Only the four low codes are real commands; everything above is noise.
    function automatic logic key_is_cmd(input logic [3:0] code);
        return code <= KEY_CLR;
    endfunction

endpackage

// File: rtl/watch_key_ctrl_wrap_counter.sv
// Up/down/clear counter that wraps modulo MAX+1; carry flags an increment
// that wraps from MAX back to zero.
module wrap_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         carry
);

    localparam logic [W-1:0] TOP = W'(MAX);

    assign carry = inc && !clr && (count == TOP);

    // Clear beats increment, increment beats decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= (count == TOP) ? '0 : count + W'(1);
        end else if (dec) begin
            count <= (count == '0) ? TOP : count - W'(1);
        end
    end

endmodule

// File: rtl/watch_key_ctrl.sv
// Watch core: keeps hh:mm:ss, applies key commands from the button front-end,
// runs the RUN/SET_H/SET_M/SET_S mode FSM and produces per-field blink enables.
module watch_key_ctrl
    import watch_pkg::*;
#(
    parameter int BLINK_DIV    = 25_000_000,
    parameter int IDLE_TIMEOUT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       tick_1hz,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic [2:0] blink,
    output logic       key_ack
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    mode_t         mode_q, mode_n;
    logic [IW-1:0] idle_q, idle_n;
    logic [BW-1:0] blink_cnt_q, blink_cnt_n;
    logic          phase_q, phase_n;
    logic [2:0]    blink_q, blink_n;
    logic          key_ack_q;

    logic accepted, k_mode, k_inc, k_dec, k_clr, in_run;
    logic sec_inc, sec_dec, sec_clr, sec_carry;
    logic min_inc, min_dec, min_carry;
    logic hr_inc, hr_dec, unused_hr_carry;

    assign accepted = key_valid && key_is_cmd(key_code);
    assign k_mode   = accepted && (key_code == KEY_MODE);
    assign k_inc    = accepted && (key_code == KEY_INC);
    assign k_dec    = accepted && (key_code == KEY_DEC);
    assign k_clr    = accepted && (key_code == KEY_CLR);
    assign in_run   = (mode_q == RUN);

    // A CLR in RUN swallows the tick of the same cycle; in SET modes time is frozen.
    assign sec_clr = k_clr && (in_run || mode_q == SET_S);
    assign sec_inc = (in_run && tick_1hz && !k_clr) || (mode_q == SET_S && k_inc);
    assign sec_dec = (mode_q == SET_S) && k_dec;
    assign min_inc = (in_run && sec_carry) || (mode_q == SET_M && k_inc);
    assign min_dec = (mode_q == SET_M) && k_dec;
    assign hr_inc  = (in_run && min_carry) || (mode_q == SET_H && k_inc);
    assign hr_dec  = (mode_q == SET_H) && k_dec;

    wrap_counter #(.W(6), .MAX(SEC_MAX)) u_seconds (
        .clk(clk), .rst(rst), .inc(sec_inc), .dec(sec_dec), .clr(sec_clr),
        .count(seconds), .carry(sec_carry)
    );

    wrap_counter #(.W(6), .MAX(MIN_MAX)) u_minutes (
        .clk(clk), .rst(rst), .inc(min_inc), .dec(min_dec), .clr(1'b0),
        .count(minutes), .carry(min_carry)
    );

    wrap_counter #(.W(5), .MAX(HOUR_MAX)) u_hours (
        .clk(clk), .rst(rst), .inc(hr_inc), .dec(hr_dec), .clr(1'b0),
        .count(hours), .carry(unused_hr_carry)
    );

    // Any accepted key, even one ignored in this mode, restarts the idle timer
    // and takes priority over a coincident tick.
    always_comb begin
        mode_n = mode_q;
        idle_n = idle_q;
        if (k_mode) begin
            idle_n = '0;
            case (mode_q)
                RUN:   mode_n = SET_H;
                SET_H: mode_n = SET_M;
                SET_M: mode_n = SET_S;
                SET_S: mode_n = RUN;
            endcase
        end else if (accepted) begin
            idle_n = '0;
        end else if (!in_run && tick_1hz) begin
            if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
                mode_n = RUN;
                idle_n = '0;
            end else begin
                idle_n = idle_q + 1'b1;
            end
        end
    end

    // Restarting the phase on a mode change keeps the new field visible at first.
    always_comb begin
        blink_cnt_n = blink_cnt_q + 1'b1;
        phase_n     = phase_q;
        if (mode_n != mode_q) begin
            blink_cnt_n = '0;
            phase_n     = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_n = '0;
            phase_n     = ~phase_q;
        end
        blink_n = {phase_n && (mode_n == SET_H),
                   phase_n && (mode_n == SET_M),
                   phase_n && (mode_n == SET_S)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= RUN;
            idle_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            blink_q     <= '0;
            key_ack_q   <= 1'b0;
        end else begin
            mode_q      <= mode_n;
            idle_q      <= idle_n;
            blink_cnt_q <= blink_cnt_n;
            phase_q     <= phase_n;
            blink_q     <= blink_n;
            key_ack_q   <= accepted;
        end
    end

    assign mode    = mode_q;
    assign blink   = blink_q;
    assign key_ack = key_ack_q;

endmodule

// File: tb/tb_watch_key_ctrl.sv
// Bench for watch_key_ctrl: a long RUN wrap sweep, then a table of key/tick
// vectors through a scoreboard queue, then a reset taken in the middle of an edit.
module tb_watch_key_ctrl;

    localparam int BLINK_DIV    = 4;
    localparam int IDLE_TIMEOUT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_code;
    logic       key_valid;
    logic       tick_1hz;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic [2:0] blink;
    logic       key_ack;

    typedef struct {
        string      name;
        logic       key_valid;
        logic [3:0] key_code;
        logic       tick;
        int         h;
        int         m;
        int         s;
        int         mode;
        int         blink;
        int         ack;
    } vec_t;

    vec_t sb_q[$];
    vec_t vecs[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    watch_key_ctrl #(
        .BLINK_DIV(BLINK_DIV),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_code(key_code),
        .key_valid(key_valid),
        .tick_1hz(tick_1hz),
        .hours(hours),
        .minutes(minutes),
        .seconds(seconds),
        .mode(mode),
        .blink(blink),
        .key_ack(key_ack)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input int kv, input int code, input int tick,
                                input int h, input int m, input int s, input int md,
                                input int bl, input int ack);
        vec_t v;
        v.name      = name;
        v.key_valid = kv[0];
        v.key_code  = code[3:0];
        v.tick      = tick[0];
        v.h         = h;
        v.m         = m;
        v.s         = s;
        v.mode      = md;
        v.blink     = bl;
        v.ack       = ack;
        return v;
    endfunction

    task automatic check_val(input string tag, input string field, input logic [31:0] act, input int exp);
        checks_total++;
        if (act === 32'(exp)) checks_passed++;
        else $display("[TB] FAIL %s %s: got %0d, expected %0d", tag, field, act, exp);
    endtask

    task automatic check_output();
        vec_t e;
        if (sb_q.size() == 0) begin
            checks_total++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb_q.pop_front();
            check_val(e.name, "hours",   32'(hours),   e.h);
            check_val(e.name, "minutes", 32'(minutes), e.m);
            check_val(e.name, "seconds", 32'(seconds), e.s);
            check_val(e.name, "mode",    32'(mode),    e.mode);
            check_val(e.name, "blink",   32'(blink),   e.blink);
            check_val(e.name, "key_ack", 32'(key_ack), e.ack);
        end
    endtask

    // Drive one cycle of stimulus just after a rising edge, check just after the next.
    task automatic apply_stimulus(input vec_t v);
        key_valid = v.key_valid;
        key_code  = v.key_code;
        tick_1hz  = v.tick;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        tick_1hz  = 1'b0;
        check_output();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // name, key_valid, code, tick, expected h, m, s, mode, blink, ack
        vecs.push_back(mk("t2_mode",         1, 0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("t2_dec1",         1, 2, 0, 23, 0, 0, 1, 0, 1));
        vecs.push_back(mk("t2_dec2",         1, 2, 0, 22, 0, 0, 1, 0, 1));
        vecs.push_back(mk("t2_idle",         0, 0, 0, 22, 0, 0, 1, 0, 0));
        vecs.push_back(mk("t2_blink_on",     0, 0, 0, 22, 0, 0, 1, 4, 0));
        vecs.push_back(mk("t2_blink_hold",   0, 0, 0, 22, 0, 0, 1, 4, 0));
        vecs.push_back(mk("t3_mode",         1, 0, 0, 22, 0, 0, 2, 0, 1));
        vecs.push_back(mk("t3_dec_wrap",     1, 2, 0, 22, 59, 0, 2, 0, 1));
        vecs.push_back(mk("t3_inc_wrap",     1, 1, 0, 22, 0, 0, 2, 0, 1));
        vecs.push_back(mk("t3_tick1",        0, 0, 1, 22, 0, 0, 2, 0, 0));
        vecs.push_back(mk("t3_tick2",        0, 0, 1, 22, 0, 0, 2, 2, 0));
        vecs.push_back(mk("t3_clr_ignored",  1, 3, 0, 22, 0, 0, 2, 2, 1));
        vecs.push_back(mk("t3_tick3",        0, 0, 1, 22, 0, 0, 2, 2, 0));
        vecs.push_back(mk("t3_tick4",        0, 0, 1, 22, 0, 0, 2, 2, 0));
        vecs.push_back(mk("t3_clr_tick5",    1, 3, 1, 22, 0, 0, 2, 0, 1));
        vecs.push_back(mk("t3_inc_tick",     1, 1, 1, 22, 1, 0, 2, 0, 1));
        vecs.push_back(mk("t3_dec",          1, 2, 0, 22, 0, 0, 2, 0, 1));
        vecs.push_back(mk("t4_mode",         1, 0, 0, 22, 0, 0, 3, 0, 1));
        vecs.push_back(mk("t4_inc",          1, 1, 0, 22, 0, 1, 3, 0, 1));
        vecs.push_back(mk("t4_dec",          1, 2, 0, 22, 0, 0, 3, 0, 1));
        vecs.push_back(mk("t4_dec_wrap",     1, 2, 0, 22, 0, 59, 3, 0, 1));
        vecs.push_back(mk("t4_clr",          1, 3, 0, 22, 0, 0, 3, 1, 1));
        vecs.push_back(mk("t4_tick1",        0, 0, 1, 22, 0, 0, 3, 1, 0));
        vecs.push_back(mk("t4_tick2",        0, 0, 1, 22, 0, 0, 3, 1, 0));
        vecs.push_back(mk("t4_timeout",      0, 0, 1, 22, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t4_run_idle",     0, 0, 0, 22, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t4_run_tick",     0, 0, 1, 22, 0, 1, 0, 0, 0));
        vecs.push_back(mk("t4_run_inc",      1, 1, 0, 22, 0, 1, 0, 0, 1));
        vecs.push_back(mk("t4_run_clr_tick", 1, 3, 1, 22, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t4_run_dec",      1, 2, 0, 22, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t5_mode_h",       1, 0, 0, 22, 0, 0, 1, 0, 1));
        vecs.push_back(mk("t5_inc_h",        1, 1, 0, 23, 0, 0, 1, 0, 1));
        vecs.push_back(mk("t5_inc_h_wrap",   1, 1, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("t5_mode_m",       1, 0, 0, 0, 0, 0, 2, 0, 1));
        vecs.push_back(mk("t5_mode_s",       1, 0, 0, 0, 0, 0, 3, 0, 1));
        vecs.push_back(mk("t5_dec_s",        1, 2, 0, 0, 0, 59, 3, 0, 1));
        vecs.push_back(mk("t5_mode_run",     1, 0, 0, 0, 0, 59, 0, 0, 1));
        vecs.push_back(mk("t5_mode_tick",    1, 0, 1, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk("t6_code5",        1, 5, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("t6_tick1",        0, 0, 1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("t6_code12",       1, 12, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("t6_code5_tick2",  1, 5, 1, 0, 1, 0, 1, 4, 0));
        vecs.push_back(mk("t6_timeout",      0, 0, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("t6_mode_h",       1, 0, 0, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk("t6_mode_m",       1, 0, 0, 0, 1, 0, 2, 0, 1));
        vecs.push_back(mk("t6_inc_m",        1, 1, 0, 0, 2, 0, 2, 0, 1));

        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        tick_1hz  = 1'b0;
        #1;
        sb_q.push_back(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_output();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] full-day sweep in RUN");
        tick_1hz = 1'b1;
        for (int t = 1; t <= 86400; t++) begin
            bit chk;
            chk = (t % 3600 == 0) || (t >= 86399);
            if (chk)
                sb_q.push_back(mk($sformatf("t1_tick%0d", t), 0, 0, 1,
                                  (t / 3600) % 24, (t / 60) % 60, t % 60, 0, 0, 0));
            @(posedge clk);
            #1;
            if (chk) check_output();
        end
        tick_1hz = 1'b0;

        $display("[TB] key/tick vector table");
        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);

        $display("[TB] reset in the middle of SET_M");
        rst = 1'b1;
        #1;
        sb_q.push_back(mk("t6_rst_async", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_output();
        key_valid = 1'b1;
        key_code  = 4'd0;
        tick_1hz  = 1'b1;
        @(posedge clk);
        #1;
        sb_q.push_back(mk("t6_rst_held", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_output();
        rst       = 1'b0;
        key_valid = 1'b0;
        tick_1hz  = 1'b0;
        apply_stimulus(mk("t6_after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply_stimulus(mk("t6_tick_after_rst", 0, 0, 1, 0, 0, 1, 0, 0, 0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
